// File: rtl/wave_gen_pkg.sv
// Shared types and constants for the wave generation datapath.
package wave_gen_pkg;

  localparam int unsigned PHASE_W  = 12;
  localparam int unsigned SAMPLE_W = 12;
  localparam logic [SAMPLE_W-1:0] SAMPLE_MID = 12'd2048;

  // Wide enough for the largest supported channel count (16).
  localparam int unsigned TAG_CH_W = 4;

  typedef struct packed {
    logic                valid;
    logic [TAG_CH_W-1:0] ch;
  } sched_tag_t;

endpackage

// File: rtl/sched_tag_pipe.sv
// Fixed-depth shift register of channel tags that tracks samples in flight through the LUT.
module sched_tag_pipe
  import wave_gen_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  sched_tag_t tag_in,
  output sched_tag_t tag_out
);

  sched_tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/wave_channel_scheduler.sv
// Round-robin DDS channel scheduler sharing one sine LUT datapath across NUM_CH channels.
// Optional per-channel phase offsets are built when WAVE_SCHED_PHASE_OFFSET_EN is defined.
module wave_channel_scheduler
  import wave_gen_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned LUT_LAT = 2,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       cfg_we,
  input  logic [CH_W-1:0]            cfg_ch,
  input  logic [ACC_W-1:0]           cfg_tuning,
  input  logic                       cfg_sync,
`ifdef WAVE_SCHED_PHASE_OFFSET_EN
  input  logic                       cfg_off_we,
  input  logic [PHASE_W-1:0]         cfg_offset,
`endif
  output logic [PHASE_W-1:0]         phase_out,
  input  logic [SAMPLE_W-1:0]        sine_in,
  output logic [NUM_CH*SAMPLE_W-1:0] ch_sample,
  output logic                       sample_valid,
  output logic [CH_W-1:0]            sample_ch,
  output logic                       frame_valid
);

  logic [ACC_W-1:0]    acc_q    [NUM_CH];
  logic [ACC_W-1:0]    tuning_q [NUM_CH];
  logic [SAMPLE_W-1:0] lane_q   [NUM_CH];
  logic [CH_W-1:0]     slot_q;
  logic [PHASE_W-1:0]  phase_q;
  logic [PHASE_W-1:0]  issue_phase;
  logic                sample_valid_q;
  logic                frame_valid_q;
  logic [CH_W-1:0]     sample_ch_q;
  sched_tag_t          issue_tag_q;
  sched_tag_t          exit_tag;

`ifdef WAVE_SCHED_PHASE_OFFSET_EN
  logic [PHASE_W-1:0] offset_q [NUM_CH];

  // Offsets survive cfg_sync; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        offset_q[i] <= '0;
      end
    end else if (cfg_off_we) begin
      offset_q[cfg_ch] <= cfg_offset;
    end
  end

  assign issue_phase = acc_q[slot_q][ACC_W-1 -: PHASE_W] + offset_q[slot_q];
`else
  assign issue_phase = acc_q[slot_q][ACC_W-1 -: PHASE_W];
`endif

  // issue_tag_q lines up with phase_out; the pipe covers the LUT latency behind it.
  sched_tag_pipe #(
    .DEPTH (LUT_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush   (cfg_sync),
    .tag_in  (issue_tag_q),
    .tag_out (exit_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        acc_q[i]    <= '0;
        tuning_q[i] <= '0;
        lane_q[i]   <= SAMPLE_MID;
      end
      slot_q         <= '0;
      phase_q        <= '0;
      issue_tag_q    <= '0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      frame_valid_q  <= 1'b0;
    end else begin
      // Issue reads tuning_q before this write lands, so a colliding write waits one round.
      if (cfg_we) begin
        tuning_q[cfg_ch] <= cfg_tuning;
      end
      if (cfg_sync) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          acc_q[i] <= '0;
        end
        slot_q         <= '0;
        phase_q        <= '0;
        issue_tag_q    <= '0;
        sample_valid_q <= 1'b0;
        frame_valid_q  <= 1'b0;
      end else begin
        if (enable) begin
          phase_q        <= issue_phase;
          acc_q[slot_q]  <= acc_q[slot_q] + tuning_q[slot_q];
          slot_q         <= (slot_q == CH_W'(NUM_CH - 1)) ? '0 : slot_q + 1'b1;
          issue_tag_q    <= '{valid: 1'b1, ch: TAG_CH_W'(slot_q)};
        end else begin
          issue_tag_q <= '0;
        end
        sample_valid_q <= exit_tag.valid;
        frame_valid_q  <= exit_tag.valid && (exit_tag.ch == TAG_CH_W'(NUM_CH - 1));
        if (exit_tag.valid) begin
          lane_q[exit_tag.ch[CH_W-1:0]] <= sine_in;
          sample_ch_q                   <= exit_tag.ch[CH_W-1:0];
        end
      end
    end
  end

  for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_lane
    assign ch_sample[k*SAMPLE_W +: SAMPLE_W] = lane_q[k];
  end

  assign phase_out    = phase_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign frame_valid  = frame_valid_q;

endmodule

// File: tb/tb_wave_channel_scheduler.sv
// Directed bench for wave_channel_scheduler with a behavioural LUT and a queue-based scoreboard.
module tb_wave_channel_scheduler;
  import wave_gen_pkg::*;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned LUT_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_tuning = '0;
  logic        cfg_sync = 1'b0;
`ifdef WAVE_SCHED_PHASE_OFFSET_EN
  logic        cfg_off_we = 1'b0;
  logic [11:0] cfg_offset = '0;
`endif
  logic [11:0] phase_out;
  logic [11:0] sine_in;
  logic [47:0] ch_sample;
  logic        sample_valid;
  logic [1:0]  sample_ch;
  logic        frame_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wave_channel_scheduler #(
    .NUM_CH  (NUM_CH),
    .ACC_W   (ACC_W),
    .LUT_LAT (LUT_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_tuning   (cfg_tuning),
    .cfg_sync     (cfg_sync),
`ifdef WAVE_SCHED_PHASE_OFFSET_EN
    .cfg_off_we   (cfg_off_we),
    .cfg_offset   (cfg_offset),
`endif
    .phase_out    (phase_out),
    .sine_in      (sine_in),
    .ch_sample    (ch_sample),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .frame_valid  (frame_valid)
  );

  function automatic logic [11:0] lut_f(input logic [11:0] p);
    logic [31:0] t;
    t = 32'(p) * 32'd7 + 32'd13;
    return t[11:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sine datapath stand-in: LUT_LAT registered stages from phase_out to sine_in.
  logic [11:0] lut_q [LUT_LAT];
  always @(posedge clk) begin
    lut_q[0] <= lut_f(phase_out);
    for (int i = 1; i < int'(LUT_LAT); i++) lut_q[i] <= lut_q[i-1];
  end
  assign sine_in = lut_q[LUT_LAT-1];

  // Scoreboard: each issue schedules one capture LUT_LAT+1 edges later.
  typedef struct {
    int          due;
    int          ch;
    logic [11:0] val;
  } cap_t;

  cap_t        pend[$];
  logic [31:0] m_acc [4];
  logic [31:0] m_tun [4];
  logic [11:0] m_off [4];
  logic [11:0] m_lane [4];
  logic [11:0] m_phase;
  int          m_slot;
  int          m_ch;
  logic        m_valid;
  logic        m_frame;
  int          edge_n = 0;
  bit          m_live = 0;

  always @(posedge clk) begin
    cap_t c;
    edge_n++;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_acc[i] = '0; m_tun[i] = '0; m_off[i] = '0; m_lane[i] = 12'd2048;
      end
      m_phase = '0; m_slot = 0; m_ch = 0; m_valid = 0; m_frame = 0;
      pend.delete();
      m_live = 1;
    end else begin
      m_valid = 0;
      m_frame = 0;
      if (cfg_sync) begin
        for (int i = 0; i < 4; i++) m_acc[i] = '0;
        m_slot = 0;
        m_phase = '0;
        pend.delete();
      end else begin
        if (pend.size() > 0 && pend[0].due == edge_n) begin
          c = pend.pop_front();
          m_lane[c.ch] = c.val;
          m_valid = 1;
          m_ch = c.ch;
          m_frame = (c.ch == int'(NUM_CH) - 1);
        end
        if (enable) begin
          m_phase = m_acc[m_slot][31:20] + m_off[m_slot];
          pend.push_back('{due: edge_n + int'(LUT_LAT) + 1, ch: m_slot, val: lut_f(m_phase)});
          m_acc[m_slot] = m_acc[m_slot] + m_tun[m_slot];
          m_slot = (m_slot + 1) % int'(NUM_CH);
        end
      end
      if (cfg_we) m_tun[cfg_ch] = cfg_tuning;
`ifdef WAVE_SCHED_PHASE_OFFSET_EN
      if (cfg_off_we) m_off[cfg_ch] = cfg_offset;
`endif
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (m_live) begin
      check("phase_out", 32'(phase_out), 32'(m_phase));
      check("sample_valid", 32'(sample_valid), 32'(m_valid));
      check("frame_valid", 32'(frame_valid), 32'(m_frame));
      if (m_valid) check("sample_ch", 32'(sample_ch), 32'(m_ch));
      for (int k = 0; k < 4; k++) check("ch_sample_lane", 32'(ch_sample[k*12 +: 12]), 32'(m_lane[k]));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  logic [11:0] ph [1:22];
  logic        sv [1:22];
  logic        fv [1:22];
  logic [11:0] l0 [1:22];
  logic        dsv [1:5];
  logic [11:0] rph [1:14];
  logic        rsv [1:14];
  logic [1:0]  rsc [1:14];

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("idle_phase", 32'(phase_out), 32'd0);
    check("idle_valid", 32'(sample_valid), 32'd0);
    for (int k = 0; k < 4; k++) check("idle_lane", 32'(ch_sample[k*12 +: 12]), 32'd2048);

    // ch0 steps a quarter turn per issue.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_tuning = 32'h4000_0000;
    tick();
    cfg_we = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      ph[i] = phase_out; sv[i] = sample_valid; fv[i] = frame_valid; l0[i] = ch_sample[11:0];
    end
    check("ch0_phase_e1", 32'(ph[1]), 32'd0);
    check("ch0_phase_e5", 32'(ph[5]), 32'd1024);
    check("ch0_phase_e9", 32'(ph[9]), 32'd2048);
    check("ch0_phase_e13", 32'(ph[13]), 32'd3072);
    check("ch0_phase_e17", 32'(ph[17]), 32'd0);
    check("first_valid_early", 32'(sv[3]), 32'd0);
    check("first_valid", 32'(sv[4]), 32'd1);
    check("lane0_before", 32'(l0[3]), 32'd2048);
    check("lane0_first", 32'(l0[4]), 32'd13);
    check("lane0_second", 32'(l0[8]), 32'd3085);
    check("frame_e7", 32'(fv[7]), 32'd1);
    check("frame_e8", 32'(fv[8]), 32'd0);
    check("frame_e11", 32'(fv[11]), 32'd1);

    // Pause mid-frame (slot 2 next); ch2 gets a new word while idle.
    enable = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_tuning = 32'h1000_0000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      dsv[k] = sample_valid;
      cfg_we = 1'b0;
    end
    check("drain_1", 32'(dsv[1]), 32'd1);
    check("drain_2", 32'(dsv[2]), 32'd1);
    check("drain_3", 32'(dsv[3]), 32'd1);
    check("drain_4", 32'(dsv[4]), 32'd0);
    check("drain_5", 32'(dsv[5]), 32'd0);

    // Resume; rewrite ch2's word on the very edge ch2 issues (r5).
    enable = 1'b1;
    cfg_ch = 2'd2; cfg_tuning = 32'h2000_0000;
    for (int j = 1; j <= 14; j++) begin
      tick();
      rph[j] = phase_out; rsv[j] = sample_valid; rsc[j] = sample_ch;
      cfg_we = (j == 4);
    end
    check("resume_no_early", 32'(rsv[3]), 32'd0);
    check("resume_valid", 32'(rsv[4]), 32'd1);
    check("resume_ch", 32'(rsc[4]), 32'd2);
    check("ch2_phase_r1", 32'(rph[1]), 32'd0);
    check("ch2_phase_r5", 32'(rph[5]), 32'd256);
    check("ch2_phase_r9", 32'(rph[9]), 32'd512);
    check("ch2_phase_r13", 32'(rph[13]), 32'd1024);

    // Leave two tags in flight, then sync (with enable high and a ch3 write).
    enable = 1'b0;
    tick();
    cfg_sync = 1'b1; enable = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_tuning = 32'h0100_0000;
    tick();
    cfg_sync = 1'b0; cfg_we = 1'b0;
    check("sync_phase", 32'(phase_out), 32'd0);
    check("sync_valid", 32'(sample_valid), 32'd0);
    tick();
    check("post_sync_issue_phase", 32'(phase_out), 32'd0);
    check("post_sync_valid_d3", 32'(sample_valid), 32'd0);
    tick();
    check("post_sync_valid_d4", 32'(sample_valid), 32'd0);
    tick();
    check("post_sync_valid_d5", 32'(sample_valid), 32'd0);
    check("lane2_kept", 32'(ch_sample[35:24]), 32'd3597);
    tick();
    check("post_sync_cap", 32'(sample_valid), 32'd1);
    check("post_sync_ch", 32'(sample_ch), 32'd0);
    check("post_sync_lane0", 32'(ch_sample[11:0]), 32'd13);
    repeat (8) tick();

`ifdef WAVE_SCHED_PHASE_OFFSET_EN
    enable = 1'b0;
    cfg_off_we = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_offset = 12'd1024; cfg_tuning = '0;
    tick();
    cfg_off_we = 1'b0; cfg_we = 1'b0; cfg_sync = 1'b1;
    tick();
    cfg_sync = 1'b0; enable = 1'b1;
    repeat (2) tick();
    check("offset_ch1", 32'(phase_out), 32'd1024);
    enable = 1'b0;
    cfg_off_we = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_offset = 12'd3500;
    cfg_tuning = 32'd1000 << 20;
    tick();
    cfg_off_we = 1'b0; cfg_we = 1'b0; cfg_sync = 1'b1;
    tick();
    cfg_sync = 1'b0; enable = 1'b1;
    repeat (2) tick();
    check("offset_nowrap", 32'(phase_out), 32'd3500);
    repeat (4) tick();
    check("offset_wrap", 32'(phase_out), 32'd404);
    repeat (6) tick();
`endif

    enable = 1'b0;
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
